// File: rtl/shift_pattern_monitor.sv
// Sequence checker for a ring/Johnson counter bus: tracks successors, counts periods, flags faults.
// Optional fault counter enabled by defining PATMON_ERRCNT_EN.
module shift_pattern_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] pat,
    output logic             locked,
    output logic             err,
    output logic             cycle_pulse,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [1:0]       state,
    output logic [7:0]       err_cnt
);
    localparam int H      = WIDTH / 2;
    localparam int STEP_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRACK = 2'd2, FAULT = 2'd3} state_t;

    state_t            state_q, state_n;
    logic [WIDTH-1:0]  prev_q, prev_n, start_q, start_n;
    logic [STEP_W-1:0] step_q, step_n;
    logic              mode_q;
    logic              err_n, pulse_n, locked_n;

    // Johnson mode only looks at the low half; the upper half is masked away.
    function automatic logic [WIDTH-1:0] view(input logic [WIDTH-1:0] p, input logic m);
        logic [WIDTH-1:0] r;
        r = p;
        if (m) r[WIDTH-1:H] = '0;
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] succ(input logic [WIDTH-1:0] p, input logic m);
        logic [WIDTH-1:0] r;
        r = {p[WIDTH-2:0], p[WIDTH-1]};
        if (m) begin
            r        = '0;
            r[H-1:0] = {p[H-2:0], ~p[H-1]};
        end
        return r;
    endfunction

    function automatic logic seed_ok(input logic [WIDTH-1:0] p, input logic m);
        int n;
        n = 0;
        if (!m) return (p != '0) && (p != '1);
        for (int j = 0; j < H - 1; j++)
            if (p[j] != p[j+1]) n++;
        return n <= 1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            start_q <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            prev_q  <= prev_n;
            start_q <= start_n;
            step_q  <= step_n;
            mode_q  <= mode;
        end
    end

    always_comb begin
        state_n = state_q;
        prev_n  = prev_q;
        start_n = start_q;
        step_n  = step_q;
        err_n   = 1'b0;
        pulse_n = 1'b0;
        if (load) begin
            state_n = IDLE;
            prev_n  = '0;
            start_n = '0;
            step_n  = '0;
        end else if (mode != mode_q && state_q != IDLE) begin
            state_n = IDLE;
        end else if (sample_en) begin
            case (state_q)
                IDLE: begin
                    if (seed_ok(pat, mode)) begin
                        prev_n  = pat;
                        start_n = pat;
                        step_n  = '0;
                        state_n = ARMED;
                    end else begin
                        state_n = FAULT;
                        err_n   = 1'b1;
                    end
                end
                ARMED, TRACK: begin
                    if (view(pat, mode) != succ(prev_q, mode)) begin
                        state_n = FAULT;
                        err_n   = 1'b1;
                    end else if (step_q == STEP_W'(WIDTH - 1)) begin
                        // Last step of a period must land back on the seed.
                        if (view(pat, mode) == view(start_q, mode)) begin
                            prev_n  = pat;
                            step_n  = '0;
                            pulse_n = 1'b1;
                            state_n = TRACK;
                        end else begin
                            state_n = FAULT;
                            err_n   = 1'b1;
                        end
                    end else begin
                        prev_n  = pat;
                        step_n  = step_q + STEP_W'(1);
                        state_n = TRACK;
                    end
                end
                default: state_n = FAULT;
            endcase
        end
    end

    always_comb begin
        locked_n = (state_n == TRACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked      <= 1'b0;
            err         <= 1'b0;
            cycle_pulse <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            locked      <= locked_n;
            err         <= err_n;
            cycle_pulse <= pulse_n;
            if (pulse_n) cycle_cnt <= sat_cnt(cycle_cnt);
        end
    end

    assign state = state_q;

`ifdef PATMON_ERRCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      err_cnt <= '0;
        else if (err_n && !(&err_cnt)) err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_pattern_monitor.sv
// Bench for shift_pattern_monitor: sequence-position model checked every cycle plus directed literal checks.
module tb_shift_pattern_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_en = 1'b0;
    logic        mode = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  pat = 8'h00;
    logic        locked, err, cycle_pulse;
    logic [15:0] cycle_cnt;
    logic [1:0]  state;
    logic [7:0]  err_cnt;
    logic        locked2, err2, cycle_pulse2;
    logic [1:0]  cycle_cnt2;
    logic [1:0]  state2;
    logic [7:0]  err_cnt2;

    int tests = 0;
    int fails = 0;
    bit run_cmp = 1'b0;

`ifdef PATMON_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    shift_pattern_monitor #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .mode(mode), .load(load), .pat(pat),
        .locked(locked), .err(err), .cycle_pulse(cycle_pulse), .cycle_cnt(cycle_cnt),
        .state(state), .err_cnt(err_cnt));

    shift_pattern_monitor #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .sample_en(sample_en), .mode(mode), .load(load), .pat(pat),
        .locked(locked2), .err(err2), .cycle_pulse(cycle_pulse2), .cycle_cnt(cycle_cnt2),
        .state(state2), .err_cnt(err_cnt2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the seed plus a step count fully determine the next legal pattern.
    function automatic logic [7:0] view(input logic [7:0] p, input logic m);
        return m ? (p & 8'h0F) : p;
    endfunction

    function automatic logic [7:0] nxt(input logic [7:0] p, input logic m);
        if (!m) return ((p << 1) | (p >> 7)) & 8'hFF;
        return ((p << 1) & 8'h0E) | (p[3] ? 8'h00 : 8'h01);
    endfunction

    function automatic logic [7:0] advance(input logic [7:0] p, input logic m, input int k);
        logic [7:0] q;
        q = view(p, m);
        for (int i = 0; i < k; i++) q = nxt(q, m);
        return q;
    endfunction

    function automatic bit legal(input logic [7:0] p, input logic m);
        logic [7:0] q;
        if (!m) return (p != 8'h00) && (p != 8'hFF);
        q = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (view(p, 1'b1) == q) return 1'b1;
            q = nxt(q, 1'b1);
        end
        return 1'b0;
    endfunction

    int         m_state = 0, m_steps = 0, m_cycles = 0, m_errs = 0;
    logic [7:0] m_start = 8'h00;
    logic       m_mode_q = 1'b0, e_err = 1'b0, e_pulse = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0; m_steps <= 0; m_cycles <= 0; m_errs <= 0;
            m_start <= 8'h00; m_mode_q <= 1'b0; e_err <= 1'b0; e_pulse <= 1'b0;
        end else begin
            e_err    <= 1'b0;
            e_pulse  <= 1'b0;
            m_mode_q <= mode;
            if (load) begin
                m_state <= 0;
                m_steps <= 0;
            end else if (mode != m_mode_q && m_state != 0) begin
                m_state <= 0;
            end else if (sample_en && m_state == 0) begin
                if (legal(pat, mode)) begin
                    m_start <= pat; m_steps <= 0; m_state <= 1;
                end else begin
                    m_state <= 3; e_err <= 1'b1; m_errs <= m_errs + 1;
                end
            end else if (sample_en && m_state != 3) begin
                if (view(pat, mode) == advance(m_start, mode, m_steps + 1)) begin
                    m_state <= 2;
                    if (m_steps + 1 == 8) begin
                        m_steps <= 0; e_pulse <= 1'b1; m_cycles <= m_cycles + 1;
                    end else begin
                        m_steps <= m_steps + 1;
                    end
                end else begin
                    m_state <= 3; e_err <= 1'b1; m_errs <= m_errs + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("state", 32'(state), 32'(m_state));
            chk("locked", 32'(locked), 32'(m_state == 2));
            chk("err", 32'(err), 32'(e_err));
            chk("cycle_pulse", 32'(cycle_pulse), 32'(e_pulse));
            chk("cycle_cnt", 32'(cycle_cnt), (m_cycles > 65535) ? 32'd65535 : 32'(m_cycles));
            chk("err_cnt", 32'(err_cnt), ERRCNT ? ((m_errs > 255) ? 32'd255 : 32'(m_errs)) : 32'd0);
            chk("sat_pulse", 32'(cycle_pulse2), 32'(e_pulse));
            chk("sat_cnt", 32'(cycle_cnt2), (m_cycles > 3) ? 32'd3 : 32'(m_cycles));
        end
    end

    task automatic idle();
        @(posedge clk); #2;
    endtask

    task automatic strobe(input logic [7:0] p);
        sample_en = 1'b1; pat = p;
        @(posedge clk); #2;
        sample_en = 1'b0;
    endtask

    task automatic load_pulse();
        load = 1'b1;
        @(posedge clk); #2;
        load = 1'b0;
    endtask

    task automatic ring_period();
        logic [7:0] p;
        for (int i = 1; i <= 8; i++) begin
            p = 8'h01 << (i % 8);
            strobe(p);
        end
    endtask

    logic [3:0] jnib [9] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [3:0] jup  [9] = '{4'hA, 4'h3, 4'hF, 4'h5, 4'hC, 4'h7, 4'h0, 4'h9, 4'hE};

    initial begin
        #1 rst = 1'b1;
        #1 run_cmp = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_cnt", 32'(cycle_cnt), 32'd0);
        rst = 1'b0;
        idle();

        // Ring lock and period counting
        strobe(8'h01);
        chk("ring_armed", 32'(state), 32'd1);
        chk("ring_unlocked", 32'(locked), 32'd0);
        strobe(8'h02);
        chk("ring_track", 32'(state), 32'd2);
        chk("ring_locked", 32'(locked), 32'd1);
        for (int i = 2; i <= 8; i++) strobe(8'(8'h01 << (i % 8)));
        chk("ring_pulse", 32'(cycle_pulse), 32'd1);
        chk("ring_cnt1", 32'(cycle_cnt), 32'd1);
        idle();
        chk("ring_pulse_clear", 32'(cycle_pulse), 32'd0);
        ring_period();
        ring_period();
        chk("ring_cnt3", 32'(cycle_cnt), 32'd3);

        // Injected sequence fault
        strobe(8'h02);
        strobe(8'h04);
        strobe(8'h10);
        chk("fault_err", 32'(err), 32'd1);
        chk("fault_state", 32'(state), 32'd3);
        chk("fault_locked", 32'(locked), 32'd0);
        strobe(8'h20);
        chk("fault_hold", 32'(state), 32'd3);
        chk("fault_err_once", 32'(err), 32'd0);
        load_pulse();
        chk("fault_load_idle", 32'(state), 32'd0);
        chk("fault_cnt_kept", 32'(cycle_cnt), 32'd3);
        chk("fault_errcnt", 32'(err_cnt), ERRCNT ? 32'd1 : 32'd0);

        // Johnson period with junk in the upper nibble
        mode = 1'b1;
        idle();
        for (int i = 0; i < 9; i++) strobe({jup[i], jnib[i]});
        chk("john_pulse", 32'(cycle_pulse), 32'd1);
        chk("john_cnt", 32'(cycle_cnt), 32'd4);
        chk("john_errcnt", 32'(err_cnt), ERRCNT ? 32'd1 : 32'd0);

        // Mode change while tracking drops to IDLE quietly
        mode = 1'b0;
        idle();
        chk("mode_idle", 32'(state), 32'd0);
        chk("mode_no_err", 32'(err), 32'd0);

        // Illegal seeds
        strobe(8'h00);
        chk("seed00_state", 32'(state), 32'd3);
        chk("seed00_err", 32'(err), 32'd1);
        load_pulse();
        strobe(8'hFF);
        chk("seedFF_state", 32'(state), 32'd3);
        chk("seedFF_err", 32'(err), 32'd1);
        load_pulse();
        mode = 1'b1;
        idle();
        strobe(8'h05);
        chk("seed0101_state", 32'(state), 32'd3);
        chk("seed0101_err", 32'(err), 32'd1);
        load_pulse();
        chk("seed_errcnt", 32'(err_cnt), ERRCNT ? 32'd4 : 32'd0);
        mode = 1'b0;
        idle();

        // load and sample_en together: sample is dropped
        strobe(8'h01);
        strobe(8'h02);
        load = 1'b1; sample_en = 1'b1; pat = 8'h04;
        @(posedge clk); #2;
        load = 1'b0; sample_en = 1'b0;
        chk("load_wins", 32'(state), 32'd0);
        strobe(8'h04);
        chk("reseed_armed", 32'(state), 32'd1);
        strobe(8'h08);
        chk("reseed_track", 32'(state), 32'd2);

        // Asynchronous reset mid-period
        #1 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_cnt", 32'(cycle_cnt), 32'd0);
        chk("arst_errcnt", 32'(err_cnt), 32'd0);
        chk("arst_pulse", 32'(cycle_pulse | err), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        idle();

        // Saturation of the narrow counter
        strobe(8'h01);
        for (int k = 0; k < 5; k++) ring_period();
        chk("sat_cnt_3", 32'(cycle_cnt2), 32'd3);
        chk("sat_pulse_5th", 32'(cycle_pulse2), 32'd1);
        chk("wide_cnt_5", 32'(cycle_cnt), 32'd5);
        idle();

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift_pattern_monitor.md
Name: shift_pattern_monitor

Overview:
- Downstream checker for the ring/Johnson counter's 8-bit `out` bus.
- Samples the counter output on a strobe and verifies each sample is the legal successor of the previous one for the selected mode.
- Counts completed counter periods and flags sequence faults.
- Sits between the counter and the status/display logic; also serves as an in-system self-check.

Parameters:
- WIDTH, 8, pattern width; must be even and >=4. Ring mode uses all WIDTH bits; Johnson mode uses bits [WIDTH/2-1:0].
- CNT_W, 16, width of the completed-period counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  strobe: pat is valid this cycle.
- mode  input  1  1 = Johnson check, 0 = ring check (same encoding as the counter's mode).
- load  input  1  resync request, pulsed alongside the counter's ctrl load.
- pat  input  WIDTH  counter output sample.
- locked  output  1  high while in TRACK.
- err  output  1  one-cycle pulse on a detected fault.
- cycle_pulse  output  1  one-cycle pulse on completion of a full period.
- cycle_cnt  output  CNT_W  completed periods; saturates at all-ones.
- state  output  2  IDLE=0, ARMED=1, TRACK=2, FAULT=3.
- err_cnt  output  8  fault count (see Optional Feature).

Behaviour:
- Reset (async, rst=1): state=IDLE; locked=0, err=0, cycle_pulse=0, cycle_cnt=0, err_cnt=0; internal prev, start, step_cnt, mode_q all cleared.
- All outputs are registered. A response appears on the clk edge that samples sample_en=1, i.e. visible the cycle after the strobe.
- Successor function succ(p):
  - ring: rotate-left by 1, {p[WIDTH-2:0], p[WIDTH-1]}.
  - Johnson (low half, H=WIDTH/2): {p[H-2:0], ~p[H-1]}. Upper half is ignored.
- Both modes have period WIDTH steps.
- Legal seed:
  - ring: pat not all-zero and not all-ones.
  - Johnson: low half is a valid Johnson code, i.e. at most one 0->1 or 1->0 boundary when read as a shift-register image.
- Priority each cycle: load > mode change > sample_en.
- load=1 (any state): next state=IDLE; prev, start, step_cnt cleared; cycle_cnt and err_cnt retained; any sample_en this cycle is ignored.
- mode differs from mode_q while in ARMED/TRACK/FAULT: next state=IDLE, no err; mode_q updates every cycle.
- IDLE, sample_en:
  - seed legal: prev=start=pat, step_cnt=0, go to ARMED.
  - seed illegal: go to FAULT, err=1.
- ARMED/TRACK, sample_en:
  - pat==succ(prev): prev=pat, step_cnt+1; ARMED->TRACK.
  - If the incremented step_cnt==WIDTH: pat must equal start (guaranteed by construction; a mismatch is a fault). Then cycle_pulse=1, cycle_cnt+1 (saturating), step_cnt=0.
  - pat!=succ(prev): go to FAULT, err=1.
- FAULT: holds; samples ignored; exit only via load, a mode change, or rst.
- No sample_en: state and counters hold; pulses are 0.
- step_cnt is ceil(log2(WIDTH+1)) bits; never exceeds WIDTH.

Optional Feature:
- Macro PATMON_ERRCNT_EN.
- Defined: err_cnt increments on every err pulse, saturates at 255, is cleared only by rst.
- Undefined: err_cnt tied to 0 and no counter logic is synthesized. The port remains so the interface is identical.

Test Plan:
- Ring seed 8'h01, then 02,04,...,80,01 on consecutive strobes:
  - state IDLE->ARMED->TRACK; locked=1 after the 02 sample.
  - cycle_pulse on the 01 sample; cycle_cnt=1.
  - Two more full periods give cycle_cnt=3.
- Johnson mode, low nibble 0000,0001,0011,0111,1111,1110,1100,1000,0000 with upper nibble random: cycle_pulse once; err never asserted.
- Ring TRACK at 8'h04, inject 8'h10:
  - err pulse; state=FAULT; locked=0.
  - Further correct samples ignored.
  - load pulse -> IDLE; cycle_cnt unchanged.
  - err_cnt=1 with the macro, 0 without.
- Illegal seeds:
  - ring 8'h00 -> FAULT with err.
  - ring 8'hFF -> FAULT with err.
  - Johnson nibble 0101 -> FAULT with err.
- Simultaneous and mid-operation events:
  - load and sample_en in the same cycle while in TRACK -> IDLE, the sample is ignored.
  - Toggle mode in TRACK -> IDLE with no err.
  - rst asserted mid-period -> all outputs 0 asynchronously, before the next clk edge.
- Saturation: CNT_W=2 override, run 5 periods -> cycle_cnt saturates at 3; cycle_pulse still fires on each period.
